uart_fifo_loopback: RTL and testbench

- Parametrised successor to the team's direct UART rx-to-tx echo top.
- Receives serial frames on rx_data and buffers valid bytes in an internal synchronous FIFO.
- Retransmits them in order on tx_data.
- Adds configurable baud, data width and parity, plus error flags, FIFO occupancy and a TX pause input.
- Sits at the board top level as the host link for the MNIST image/result path.

---
 rtl/uart_pkg.sv | 32 +++
 rtl/uart_sync_fifo.sv | 49 ++++
 rtl/uart_fifo_loopback.sv | 254 +++++++++++++++++++++++++
 tb/tb_uart_fifo_loopback.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART loopback: baud divisor, parity modes,
// FSM state encoding and parity computation.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_t;

  function automatic int calc_baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Unused upper data bits are zero, so reducing over all 8 bits is safe.
  function automatic logic calc_parity(input logic [7:0] data, input int mode);
    logic p;
    p = ^data;
    case (mode)
      PAR_ODD:  return ~p;
      PAR_EVEN: return p;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered occupancy; a push while full is ignored
// unless a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           sys_clk,
  input  logic                           sys_rst_n,
  input  logic                           push,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/uart_fifo_loopback.sv
// UART receiver -> FIFO -> UART transmitter echo path with parity, error
// flags and a transmit pause.
//
// state  | meaning
// IDLE   | line idle; RX waits for a falling edge, TX waits for data
// START  | start bit (RX checks it at mid-bit to reject glitches)
// DATA   | payload bits, LSB first
// PARITY | parity bit, only when parity is enabled
// STOP   | stop bit; RX evaluates the frame at mid-bit
module uart_fifo_loopback
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = PAR_NONE,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              sys_clk,
  input  logic                              sys_rst_n,
  input  logic                              rx_data,
  output logic                              tx_data,
  input  logic                              tx_pause,
  output logic                              tx_busy,
  output logic                              rx_done,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overflow,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int               BAUD_DIV = calc_baud_div(CLK_FREQ, BAUD);
  localparam int               CNT_W    = $clog2(BAUD_DIV);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_HALF = CNT_W'(BAUD_DIV / 2);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);
  localparam logic             HAS_PAR  = (PARITY != PAR_NONE);

  logic rx_meta, rx_sync, rx_prev;

  uart_state_t          rx_state, rx_state_d;
  logic [CNT_W-1:0]     rx_cnt, rx_cnt_d;
  logic [2:0]           rx_bit, rx_bit_d;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_d;
  logic                 rx_par, rx_par_d;
  logic                 rx_done_d, frame_err_d, parity_err_d;

  uart_state_t          tx_state, tx_state_d;
  logic [CNT_W-1:0]     tx_cnt, tx_cnt_d;
  logic [2:0]           tx_bit, tx_bit_d;
  logic [DATA_BITS-1:0] tx_shift, tx_shift_d;
  logic                 tx_par, tx_par_d;
  logic                 tx_pop, tx_line, can_start;

  logic       fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx_data;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rx_state   <= ST_IDLE;
      rx_cnt     <= '0;
      rx_bit     <= '0;
      rx_shift   <= '0;
      rx_par     <= 1'b0;
      rx_done    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      rx_state   <= rx_state_d;
      rx_cnt     <= rx_cnt_d;
      rx_bit     <= rx_bit_d;
      rx_shift   <= rx_shift_d;
      rx_par     <= rx_par_d;
      rx_done    <= rx_done_d;
      frame_err  <= frame_err_d;
      parity_err <= parity_err_d;
    end
  end

  always_comb begin
    rx_state_d   = rx_state;
    rx_cnt_d     = rx_cnt;
    rx_bit_d     = rx_bit;
    rx_shift_d   = rx_shift;
    rx_par_d     = rx_par;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    if (rx_state != ST_IDLE && rx_cnt != '0) rx_cnt_d = rx_cnt - CNT_W'(1);
    case (rx_state)
      ST_IDLE: begin
        if (rx_prev && !rx_sync) begin
          rx_state_d = ST_START;
          rx_cnt_d   = DIV_HALF;
        end
      end
      ST_START: begin
        if (rx_cnt == '0) begin
          rx_state_d = rx_sync ? ST_IDLE : ST_DATA;
          rx_cnt_d   = DIV_LAST;
          rx_bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (rx_cnt == '0) begin
          rx_shift_d = {rx_sync, rx_shift[DATA_BITS-1:1]};
          rx_cnt_d   = DIV_LAST;
          if (rx_bit == LAST_BIT) rx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          else                    rx_bit_d   = rx_bit + 3'(1);
        end
      end
      ST_PARITY: begin
        if (rx_cnt == '0) begin
          rx_par_d   = rx_sync;
          rx_cnt_d   = DIV_LAST;
          rx_state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        // Returning to IDLE at mid-stop lets the next start edge be caught.
        if (rx_cnt == '0) begin
          rx_state_d = ST_IDLE;
          if (!rx_sync) frame_err_d = 1'b1;
          else if (HAS_PAR && rx_par != calc_parity(8'(rx_shift), PARITY)) parity_err_d = 1'b1;
          else rx_done_d = 1'b1;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  uart_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .push      (rx_done),
    .wr_data   (8'(rx_shift)),
    .pop       (tx_pop),
    .rd_data   (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign can_start = !fifo_empty && !tx_pause;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_state <= ST_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      tx_par   <= 1'b0;
    end else begin
      tx_state <= tx_state_d;
      tx_cnt   <= tx_cnt_d;
      tx_bit   <= tx_bit_d;
      tx_shift <= tx_shift_d;
      tx_par   <= tx_par_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state;
    tx_cnt_d   = tx_cnt;
    tx_bit_d   = tx_bit;
    tx_shift_d = tx_shift;
    tx_par_d   = tx_par;
    tx_pop     = 1'b0;
    tx_line    = 1'b1;
    if (tx_state != ST_IDLE && tx_cnt != '0) tx_cnt_d = tx_cnt - CNT_W'(1);
    case (tx_state)
      ST_START:  tx_line = 1'b0;
      ST_DATA:   tx_line = tx_shift[0];
      ST_PARITY: tx_line = tx_par;
      default:   tx_line = 1'b1;
    endcase
    case (tx_state)
      ST_IDLE: begin
        if (can_start) begin
          tx_pop     = 1'b1;
          tx_state_d = ST_START;
          tx_cnt_d   = DIV_LAST;
          tx_shift_d = fifo_rdata[DATA_BITS-1:0];
          tx_par_d   = calc_parity(fifo_rdata, PARITY);
        end
      end
      ST_START: begin
        if (tx_cnt == '0) begin
          tx_state_d = ST_DATA;
          tx_cnt_d   = DIV_LAST;
          tx_bit_d   = '0;
        end
      end
      ST_DATA: begin
        if (tx_cnt == '0) begin
          tx_shift_d = tx_shift >> 1;
          tx_cnt_d   = DIV_LAST;
          if (tx_bit == LAST_BIT) tx_state_d = HAS_PAR ? ST_PARITY : ST_STOP;
          else                    tx_bit_d   = tx_bit + 3'(1);
        end
      end
      ST_PARITY: begin
        if (tx_cnt == '0) begin
          tx_state_d = ST_STOP;
          tx_cnt_d   = DIV_LAST;
        end
      end
      ST_STOP: begin
        if (tx_cnt == '0) begin
          if (can_start) begin
            tx_pop     = 1'b1;
            tx_state_d = ST_START;
            tx_cnt_d   = DIV_LAST;
            tx_shift_d = fifo_rdata[DATA_BITS-1:0];
            tx_par_d   = calc_parity(fifo_rdata, PARITY);
          end else begin
            tx_state_d = ST_IDLE;
          end
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
  end

  // Line and busy are registered one cycle behind the state so the wire
  // stays glitch-free; busy covers the pop through the last stop cycle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tx_data  <= 1'b1;
      tx_busy  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      tx_data  <= tx_line;
      tx_busy  <= (tx_state != ST_IDLE) || (tx_state_d != ST_IDLE);
      overflow <= rx_done && fifo_full && !tx_pop;
    end
  end

endmodule

// File: tb/tb_uart_fifo_loopback.sv
// Directed bench: three loopback instances (default rate, fast rate, fast rate
// with 7-bit even parity) driven by a serial frame generator and a line decoder.
module tb_uart_fifo_loopback;

  typedef struct {
    int data;
    int par;
    int ok;
    int t;
  } rec_t;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       rx_a, rx_b, rx_c;
  logic       pause_a, pause_b, pause_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;
  logic       done_a, done_b, done_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       perr_a, perr_b, perr_c;
  logic       ovf_a, ovf_b, ovf_c;
  logic [4:0] cnt_a, cnt_b, cnt_c;

  int errors = 0;
  int checks = 0;

  int n_done [3] = '{0, 0, 0};
  int n_ferr [3] = '{0, 0, 0};
  int n_perr [3] = '{0, 0, 0};
  int n_ovf  [3] = '{0, 0, 0};

  rec_t q_a[$], q_b[$], q_c[$];

  always #5 sys_clk = ~sys_clk;

  uart_fifo_loopback u_a (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_a), .tx_data(tx_a),
    .tx_pause(pause_a), .tx_busy(busy_a), .rx_done(done_a), .frame_err(ferr_a),
    .parity_err(perr_a), .overflow(ovf_a), .fifo_count(cnt_a));

  uart_fifo_loopback #(.CLK_FREQ(1_600_000), .BAUD(100_000)) u_b (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_b), .tx_data(tx_b),
    .tx_pause(pause_b), .tx_busy(busy_b), .rx_done(done_b), .frame_err(ferr_b),
    .parity_err(perr_b), .overflow(ovf_b), .fifo_count(cnt_b));

  uart_fifo_loopback #(.CLK_FREQ(1_600_000), .BAUD(100_000), .DATA_BITS(7), .PARITY(2)) u_c (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_data(rx_c), .tx_data(tx_c),
    .tx_pause(pause_c), .tx_busy(busy_c), .rx_done(done_c), .frame_err(ferr_c),
    .parity_err(perr_c), .overflow(ovf_c), .fifo_count(cnt_c));

  function automatic int div_of(input int i);
    return (i == 0) ? 434 : 16;
  endfunction

  function automatic int nb_of(input int i);
    return (i == 2) ? 7 : 8;
  endfunction

  function automatic int pb_of(input int i);
    return (i == 2) ? 1 : 0;
  endfunction

  always @(negedge sys_clk) begin
    if (done_a) n_done[0]++;
    if (done_b) n_done[1]++;
    if (done_c) n_done[2]++;
    if (ferr_a) n_ferr[0]++;
    if (ferr_b) n_ferr[1]++;
    if (ferr_c) n_ferr[2]++;
    if (perr_a) n_perr[0]++;
    if (perr_b) n_perr[1]++;
    if (perr_c) n_perr[2]++;
    if (ovf_a)  n_ovf[0]++;
    if (ovf_b)  n_ovf[1]++;
    if (ovf_c)  n_ovf[2]++;
  end

  // Line decoder: samples each TX line at mid-bit and records every frame.
  int          cyc = 0;
  int          d_st  [3] = '{0, 0, 0};
  int          d_cnt [3];
  int          d_bit [3];
  int          d_t   [3];
  logic [11:0] d_frm [3];
  logic        dec_ln;
  int          dec_nb, dec_nf;
  rec_t        dec_r;

  always @(negedge sys_clk) begin
    cyc++;
    for (int i = 0; i < 3; i++) begin
      dec_ln = (i == 0) ? tx_a : (i == 1) ? tx_b : tx_c;
      dec_nb = nb_of(i);
      dec_nf = 2 + dec_nb + pb_of(i);
      if (!sys_rst_n) begin
        d_st[i] = 0;
      end else if (d_st[i] == 0) begin
        if (dec_ln == 1'b0) begin
          d_st[i]  = 1;
          d_cnt[i] = div_of(i) / 2;
          d_bit[i] = 0;
          d_t[i]   = cyc;
          d_frm[i] = '0;
        end
      end else begin
        d_cnt[i]--;
        if (d_cnt[i] == 0) begin
          d_frm[i][d_bit[i]] = dec_ln;
          d_cnt[i] = div_of(i);
          if (d_bit[i] == dec_nf - 1) begin
            dec_r.data = int'((d_frm[i] >> 1) & ((12'd1 << dec_nb) - 12'd1));
            dec_r.par  = (pb_of(i) != 0) ? int'(d_frm[i][dec_nb+1]) : 0;
            dec_r.ok   = (d_frm[i][0] == 1'b0 && d_frm[i][dec_nf-1] == 1'b1) ? 1 : 0;
            dec_r.t    = d_t[i];
            case (i)
              0:       q_a.push_back(dec_r);
              1:       q_b.push_back(dec_r);
              default: q_c.push_back(dec_r);
            endcase
            d_st[i] = 0;
          end else begin
            d_bit[i]++;
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic set_rx(input int sel, input logic v);
    case (sel)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  task automatic hold(input int sel, input logic v, input int n);
    set_rx(sel, v);
    cycles(n);
  endtask

  task automatic send(input int sel, input logic [7:0] d, input int nb,
                      input int use_par, input logic pbit, input logic stop);
    int dv;
    dv = div_of(sel);
    hold(sel, 1'b0, dv);
    for (int k = 0; k < nb; k++) hold(sel, d[k], dv);
    if (use_par != 0) hold(sel, pbit, dv);
    hold(sel, stop, dv);
    set_rx(sel, 1'b1);
  endtask

  int         lat, bad, k, base_done, base_ferr, base_perr, base_q, lows;
  logic [9:0] exp_bits;

  initial begin
    rx_a = 1'b1; rx_b = 1'b1; rx_c = 1'b1;
    pause_a = 1'b0; pause_b = 1'b0; pause_c = 1'b0;
    sys_rst_n = 1'b0;
    cycles(5);
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_flags", {done_a, ferr_a, perr_a, ovf_a}, 0);
    chk("rst_count", cnt_b, 0);
    sys_rst_n = 1'b1;
    cycles(5);

    // 0xA5 at the default rate: latency and bit-exact echo.
    fork
      send(0, 8'hA5, 8, 0, 1'b0, 1'b1);
      begin
        k = 0;
        while (!done_a && k < 20000) begin cycles(1); k++; end
        chk("a5_done_seen", done_a, 1);
        lat = 0;
        while (tx_a && lat < 10) begin cycles(1); lat++; end
        chk("a5_latency", lat, 3);
        chk("a5_busy_mid", busy_a, 1);
        exp_bits = {1'b1, 8'hA5, 1'b0};
        bad = 0;
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < 434; c++) begin
            if (b != 0 || c != 0) cycles(1);
            if (tx_a !== exp_bits[b]) bad++;
          end
        chk("a5_bits", bad, 0);
        cycles(1);
        chk("a5_busy_end", busy_a, 0);
      end
    join
    chk("a5_done_count", n_done[0], 1);
    chk("a5_echo", (q_a.size() > 0) ? q_a[0].data : -1, 8'hA5);

    // Overflow with TX paused, then back-to-back drain.
    pause_b = 1'b1;
    for (int v = 0; v < 16; v++) send(1, 8'(v), 8, 0, 1'b0, 1'b1);
    chk("ovf_count16", cnt_b, 16);
    chk("ovf_none_yet", n_ovf[1], 0);
    send(1, 8'h10, 8, 0, 1'b0, 1'b1);
    chk("ovf_pulse", n_ovf[1], 1);
    chk("ovf_count_hold", cnt_b, 16);
    chk("ovf_done17", n_done[1], 17);
    pause_b = 1'b0;
    k = 0;
    while ((cnt_b !== 5'd0 || busy_b !== 1'b0) && k < 5000) begin cycles(1); k++; end
    chk("drain_count", cnt_b, 0);
    cycles(5);
    chk("drain_frames", q_b.size(), 16);
    bad = 0;
    for (int i = 0; i < q_b.size(); i++) begin
      if (q_b[i].data != i || q_b[i].ok != 1) bad++;
      if (i > 0 && q_b[i].t - q_b[i-1].t != 160) bad++;
    end
    chk("drain_order_gap", bad, 0);

    // Stop bit forced low.
    base_done = n_done[1]; base_ferr = n_ferr[1]; base_perr = n_perr[1];
    send(1, 8'h3C, 8, 0, 1'b0, 1'b0);
    cycles(40);
    chk("ferr_pulse", n_ferr[1] - base_ferr, 1);
    chk("ferr_no_done", n_done[1] - base_done, 0);
    chk("ferr_no_perr", n_perr[1] - base_perr, 0);
    chk("ferr_count", cnt_b, 0);
    cycles(200);
    chk("ferr_no_tx", q_b.size(), 16);

    // 7-bit even parity: 0x07 needs parity bit 1.
    send(2, 8'h07, 7, 1, 1'b0, 1'b1);
    cycles(20);
    chk("par_bad_err", n_perr[2], 1);
    chk("par_bad_drop", n_done[2], 0);
    chk("par_bad_count", cnt_c, 0);
    send(2, 8'h07, 7, 1, 1'b1, 1'b1);
    cycles(200);
    chk("par_ok_done", n_done[2], 1);
    chk("par_ok_perr", n_perr[2], 1);
    chk("par_ok_frames", q_c.size(), 1);
    chk("par_ok_data", (q_c.size() > 0) ? q_c[0].data : -1, 7);
    chk("par_ok_bit", (q_c.size() > 0) ? q_c[0].par : -1, 1);

    // Short low glitch on an idle line, then a real frame.
    base_done = n_done[1]; base_ferr = n_ferr[1]; base_perr = n_perr[1];
    hold(1, 1'b0, 4);
    set_rx(1, 1'b1);
    cycles(40);
    chk("glitch_flags", (n_done[1] - base_done) + (n_ferr[1] - base_ferr) + (n_perr[1] - base_perr), 0);
    send(1, 8'h81, 8, 0, 1'b0, 1'b1);
    cycles(200);
    chk("glitch_done", n_done[1] - base_done, 1);
    chk("glitch_echo", (q_b.size() == 17) ? q_b[16].data : -1, 8'h81);

    // Reset in the middle of a TX data bit with bytes queued.
    pause_b = 1'b1;
    send(1, 8'hF0, 8, 0, 1'b0, 1'b1);
    send(1, 8'h22, 8, 0, 1'b0, 1'b1);
    send(1, 8'h33, 8, 0, 1'b0, 1'b1);
    chk("rstq_count3", cnt_b, 3);
    pause_b = 1'b0;
    k = 0;
    while (tx_b && k < 100) begin cycles(1); k++; end
    cycles(24);
    chk("rstq_pre_tx", tx_b, 0);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("rstq_tx", tx_b, 1);
    chk("rstq_count", cnt_b, 0);
    chk("rstq_busy", busy_b, 0);
    cycles(3);
    sys_rst_n = 1'b1;
    base_q = q_b.size();
    lows = 0;
    for (int i = 0; i < 500; i++) begin
      cycles(1);
      if (tx_b !== 1'b1) lows++;
    end
    chk("rstq_silent", lows, 0);
    chk("rstq_no_frames", q_b.size() - base_q, 0);
    chk("rstq_count_after", cnt_b, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
